// File: rtl/shiftreg4_behav_pkg.sv
// rtl/shiftreg4_behav_pkg.sv - shared constants and implementation selector for the serial delay line
package shiftreg4_behav_pkg;

    localparam int   SHREG_DEPTH_DEFAULT = 4;
    localparam logic SHREG_RST_VAL       = 1'b0;

    // Behavioural vector is the reference; the flop chain is the equivalence target.
    typedef enum logic {
        SHREG_IMPL_BEHAV = 1'b0,
        SHREG_IMPL_CHAIN = 1'b1
    } shreg_impl_e;

endpackage

// File: rtl/shiftreg4_behav_dff_ar.sv
// rtl/shiftreg4_behav_dff_ar.sv - 1-bit D flop with async active-low reset and parameterised reset value
module dff_ar #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/shiftreg4_behav.sv
// rtl/shiftreg4_behav.sv - serial-in serial-out shift register delaying din by DEPTH clock edges
module shiftreg4_behav
    import shiftreg4_behav_pkg::*;
#(
    parameter int          DEPTH   = SHREG_DEPTH_DEFAULT,
    parameter logic        RST_VAL = SHREG_RST_VAL,
    parameter shreg_impl_e IMPL    = SHREG_IMPL_BEHAV
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    // q[0] is the input stage, q[DEPTH-1] drives dout directly.
    logic [DEPTH-1:0] q;

    generate
        if (IMPL == SHREG_IMPL_BEHAV) begin : g_behav
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    q <= {DEPTH{RST_VAL}};
                end else begin
                    q <= {q[DEPTH-2:0], din};
                end
            end
        end else begin : g_chain
            logic [DEPTH-1:0] stage_d;

            assign stage_d = {q[DEPTH-2:0], din};

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                dff_ar #(
                    .RST_VAL (RST_VAL)
                ) u_dff (
                    .clk (clk),
                    .rst (rst),
                    .d   (stage_d[i]),
                    .q   (q[i])
                );
            end
        end
    endgenerate

    assign dout = q[DEPTH-1];

endmodule

// File: tb/tb_shiftreg4_behav.sv
// tb/tb_shiftreg4_behav.sv - self-checking bench for shiftreg4_behav at depths 2, 4, 8 and the flop-chain variant
module tb_shiftreg4_behav;
    import shiftreg4_behav_pkg::*;

    localparam logic RV = SHREG_RST_VAL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout4, dout2, dout8, dout4c;

    int checks   = 0;
    int failures = 0;
    int first4, first2, first8, ones4;

    // Every din value captured since the last reset, oldest first.
    bit hist[$];

    always #15 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) hist.delete();
        else      hist.push_back(din);
    end

    shiftreg4_behav #(.DEPTH(4)) dut4 (.clk(clk), .rst(rst), .din(din), .dout(dout4));
    shiftreg4_behav #(.DEPTH(2)) dut2 (.clk(clk), .rst(rst), .din(din), .dout(dout2));
    shiftreg4_behav #(.DEPTH(8)) dut8 (.clk(clk), .rst(rst), .din(din), .dout(dout8));
    shiftreg4_behav #(.DEPTH(4), .IMPL(SHREG_IMPL_CHAIN)) dut4c (.clk(clk), .rst(rst), .din(din), .dout(dout4c));

    function automatic logic expect_dout(int d);
        if (hist.size() >= d) return hist[hist.size() - d];
        return RV;
    endfunction

    task automatic check_vec(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all(string tag);
        check_vec({tag, "/d4"},  {7'd0, dout4},  {7'd0, expect_dout(4)});
        check_vec({tag, "/d2"},  {7'd0, dout2},  {7'd0, expect_dout(2)});
        check_vec({tag, "/d8"},  {7'd0, dout8},  {7'd0, expect_dout(8)});
        check_vec({tag, "/d4c"}, {7'd0, dout4c}, {7'd0, expect_dout(4)});
    endtask

    // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic step(logic v, string tag);
        din = v;
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        // Reset held from the start; din activity must not leak through.
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din = ~din;
            check_all("reset_hold");
            check_vec("reset_dout4", {7'd0, dout4}, 8'd0);
        end

        // Single-one impulse, released mid-cycle.
        @(negedge clk);
        din = 1'b0;
        #5 rst = 1'b1;
        first4 = 0; first2 = 0; first8 = 0; ones4 = 0;
        for (int e = 1; e <= 12; e++) begin
            step((e == 1) ? 1'b1 : 1'b0, "impulse");
            if (dout4 === 1'b1) begin
                ones4++;
                if (first4 == 0) first4 = e;
            end
            if (dout2 === 1'b1 && first2 == 0) first2 = e;
            if (dout8 === 1'b1 && first8 == 0) first8 = e;
        end
        check_vec("impulse_lat4", 8'(first4), 8'd4);
        check_vec("impulse_lat2", 8'(first2), 8'd2);
        check_vec("impulse_lat8", 8'(first8), 8'd8);
        check_vec("impulse_width4", 8'(ones4), 8'd1);

        // Pattern 1,0,1,1,0,0,1,0.
        begin
            logic [7:0] pat;
            pat = 8'b1011_0010;
            for (int i = 0; i < 8; i++) begin
                step(pat[7 - i], "pattern");
                if (i == 3) check_vec("pattern_q4", {4'd0, dut4.q}, 8'h0B);
            end
            for (int i = 0; i < 8; i++) step(1'b0, "pattern_flush");
        end

        // din toggling every 12 ns, never coincident with a rising edge.
        fork
            begin
                for (int i = 0; i < 48; i++) #12 din = ~din;
            end
        join_none
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_all("async_din");
        end

        // Load ones, then a 5 ns reset pulse between edges.
        for (int i = 0; i < 8; i++) step(1'b1, "load_ones");
        check_vec("loaded_q4", {4'd0, dut4.q}, 8'h0F);
        #5 rst = 1'b0;
        #1;
        check_all("midreset_drop");
        check_vec("midreset_q4", {4'd0, dut4.q}, 8'h00);
        #4 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) step(1'b0, "post_reset_zeros");
        for (int i = 0; i < 4; i++) step(1'b1, "post_reset_data");

        // Randomised stream with one reset pulse partway through.
        for (int i = 0; i < 60; i++) begin
            if (i == 30) begin
                #7 rst = 1'b0;
                #1 check_all("rand_reset");
                #3 rst = 1'b1;
                @(negedge clk);
            end
            step(1'($urandom_range(0, 1)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
